// File: rtl/psdsqrt_pkg.sv
// Shared constants and FSM state encoding for the psdsqrt start/stop driver.
package psdsqrt_pkg;

   localparam int NBX   = 32;
   localparam int NBR   = 16;
   localparam int NITER = 16;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_RUN     = 3'd2,
      S_STOP    = 3'd3,
      S_CAPTURE = 3'd4,
      S_HOLD    = 3'd5
   } state_t;

endpackage

// File: rtl/psdsqrt_check.sv
// Combinational range check of a root candidate: err=1 unless r*r <= x < (r+1)^2.
module psdsqrt_check
   import psdsqrt_pkg::*;
#(
   parameter int NBX = psdsqrt_pkg::NBX,
   parameter int NBR = psdsqrt_pkg::NBR
) (
   input  logic [NBX-1:0] x,
   input  logic [NBR-1:0] r,
   output logic           err
);

   // One extra bit so (r+1)^2 cannot overflow when r is all ones.
   logic [NBX:0] r_ext;
   logic [NBX:0] r_inc;
   logic [NBX:0] lo;
   logic [NBX:0] hi;
   logic [NBX:0] x_ext;

   assign r_ext = {{(NBX-NBR+1){1'b0}}, r};
   assign r_inc = r_ext + 1'b1;
   assign lo    = r_ext * r_ext;
   assign hi    = r_inc * r_inc;
   assign x_ext = {1'b0, x};
   assign err   = !((lo <= x_ext) && (x_ext < hi));

endmodule

// File: rtl/psdsqrt_driver.sv
// Request/response initiator that sequences one psdsqrt core through start,
// a fixed iteration window and stop, then returns the captured root.
module psdsqrt_driver
   import psdsqrt_pkg::*;
#(
   parameter int NBX   = psdsqrt_pkg::NBX,
   parameter int NBR   = psdsqrt_pkg::NBR,
   parameter int NITER = psdsqrt_pkg::NITER,
   parameter int GAP   = 0,
   parameter int CHECK = 1
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [NBX-1:0] req_x,
   output logic           res_valid,
   input  logic           res_ready,
   output logic [NBR-1:0] res_sqrt,
   output logic [NBX-1:0] res_x,
   output logic           res_err,
   output logic [NBX-1:0] core_x,
   output logic           core_start,
   output logic           core_stop,
   input  logic [NBR-1:0] core_sqrt,
   output logic           busy
);

   localparam int TOT = NITER + GAP;
   localparam int CW  = $clog2(TOT + 1);
   localparam logic [CW-1:0] LAST = CW'(TOT - 1);

   state_t         state;
   logic [CW-1:0]  count;
   logic [NBX-1:0] x_reg;
   logic           err_w;

   generate
      if (CHECK != 0) begin : g_check
         psdsqrt_check #(.NBX(NBX), .NBR(NBR)) u_check (
            .x   (x_reg),
            .r   (core_sqrt),
            .err (err_w)
         );
      end else begin : g_nocheck
         assign err_w = 1'b0;
      end
   endgenerate

   // Pulses default low each cycle; only the transitions into START/STOP raise them.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_IDLE;
         req_ready  <= 1'b1;
         res_valid  <= 1'b0;
         core_start <= 1'b0;
         core_stop  <= 1'b0;
         count      <= '0;
         x_reg      <= '0;
         res_sqrt   <= '0;
         res_x      <= '0;
         res_err    <= 1'b0;
      end else begin
         core_start <= 1'b0;
         core_stop  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  x_reg      <= req_x;
                  req_ready  <= 1'b0;
                  core_start <= 1'b1;
                  state      <= S_START;
               end
            end
            S_START: begin
               count <= '0;
               state <= S_RUN;
            end
            S_RUN: begin
               if (count == LAST) begin
                  core_stop <= 1'b1;
                  state     <= S_STOP;
               end else begin
                  count <= count + 1'b1;
               end
            end
            S_STOP: begin
               state <= S_CAPTURE;
            end
            S_CAPTURE: begin
               res_sqrt  <= core_sqrt;
               res_x     <= x_reg;
               res_err   <= err_w;
               res_valid <= 1'b1;
               state     <= S_HOLD;
            end
            S_HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               res_valid <= 1'b0;
               req_ready <= 1'b1;
               state     <= S_IDLE;
            end
         endcase
      end
   end

   assign core_x = x_reg;
   assign busy   = (state != S_IDLE);

endmodule
